// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, XOR-checksummed
// byte stream, writes big-endian 32-bit words, and holds the core until the image verifies.
module imem_loader #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_ldr,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_waddr,
    output logic [31:0]           im_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                state_r;
    state_t                state_nxt;
    logic [15:0]           len_r;
    logic [23:0]           word_r;
    logic [1:0]            byte_idx_r;
    logic [7:0]            csum_r;
    logic                  in_ready_r;
    logic                  im_we_r;
    logic [ADDR_WIDTH-1:0] im_waddr_r;
    logic [31:0]           im_wdata_r;
    logic                  core_hold_r;
    logic                  load_done_r;
    logic                  load_err_r;
    logic [15:0]           word_cnt_r;

    logic                  accepting_s;
    logic                  xfer_s;
    logic                  start_ok_s;
    logic [15:0]           n_full_s;
    logic                  too_big_s;
    logic                  word_last_s;
    logic                  final_word_s;

    assign accepting_s  = (state_r == S_LEN_HI) || (state_r == S_LEN_LO) ||
                          (state_r == S_DATA)   || (state_r == S_CSUM);
    assign xfer_s       = in_valid && accepting_s;
    assign start_ok_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
    assign n_full_s     = {len_r[15:8], in_data};
    assign too_big_s    = {1'b0, n_full_s} > DEPTH;
    assign word_last_s  = (byte_idx_r == 2'd3);
    assign final_word_s = ((word_cnt_r + 16'd1) == len_r);

    // State register
    always_ff @(posedge clk or negedge rst_ldr) begin
        if (!rst_ldr) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN_HI;
                else       state_nxt = state_r;
            end
            S_LEN_HI: begin
                if (xfer_s) state_nxt = S_LEN_LO;
                else        state_nxt = state_r;
            end
            S_LEN_LO: begin
                if (!xfer_s)                   state_nxt = state_r;
                else if (too_big_s)            state_nxt = S_ERR;
                else if (n_full_s == 16'd0)    state_nxt = S_CSUM;
                else                           state_nxt = S_DATA;
            end
            S_DATA: begin
                if (xfer_s && word_last_s && final_word_s) state_nxt = S_CSUM;
                else                                       state_nxt = state_r;
            end
            S_CSUM: begin
                if (!xfer_s)                  state_nxt = state_r;
                else if (in_data == csum_r)   state_nxt = S_DONE;
                else                          state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath, write port and status outputs (status derived from the next state)
    always_ff @(posedge clk or negedge rst_ldr) begin
        if (!rst_ldr) begin
            len_r       <= 16'd0;
            word_r      <= 24'd0;
            byte_idx_r  <= 2'd0;
            csum_r      <= 8'd0;
            in_ready_r  <= 1'b0;
            im_we_r     <= 1'b0;
            im_waddr_r  <= BASE_ADDR;
            im_wdata_r  <= 32'd0;
            core_hold_r <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
            word_cnt_r  <= 16'd0;
        end else begin
            im_we_r     <= 1'b0;
            in_ready_r  <= (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                           (state_nxt == S_DATA)   || (state_nxt == S_CSUM);
            load_done_r <= (state_nxt == S_DONE);
            load_err_r  <= (state_nxt == S_ERR);
            core_hold_r <= (state_nxt != S_DONE);
            if (start_ok_s) begin
                word_cnt_r <= 16'd0;
                csum_r     <= 8'd0;
                byte_idx_r <= 2'd0;
            end else if (xfer_s) begin
                case (state_r)
                    S_LEN_HI: begin
                        len_r[15:8] <= in_data;
                        csum_r      <= csum_step(csum_r, in_data);
                    end
                    S_LEN_LO: begin
                        len_r[7:0] <= in_data;
                        csum_r     <= csum_step(csum_r, in_data);
                    end
                    S_DATA: begin
                        csum_r     <= csum_step(csum_r, in_data);
                        word_r     <= {word_r[15:0], in_data};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (word_last_s) begin
                            im_we_r    <= 1'b1;
                            im_wdata_r <= {word_r, in_data};
                            im_waddr_r <= BASE_ADDR + word_cnt_r[ADDR_WIDTH-1:0];
                            word_cnt_r <= word_cnt_r + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign im_we     = im_we_r;
    assign im_waddr  = im_waddr_r;
    assign im_wdata  = im_wdata_r;
    assign core_hold = core_hold_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;
    assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int BASE  = 0;

    logic          clk = 1'b0;
    logic          rst_ldr;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;
    logic [15:0]   word_cnt;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(10'd0)) dut (
        .clk(clk), .rst_ldr(rst_ldr), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .core_hold(core_hold), .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          wr_seen = 0;
    logic [7:0]  byte_q[$];
    logic [31:0] word_q[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;
    int          exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: stream bytes, expected writes and final outcome from word_q.
    task automatic model_build(input int n, input bit bad_csum);
        logic [15:0] nn;
        logic [7:0]  x;
        logic [31:0] w;
        nn = n[15:0];
        x  = 8'd0;
        byte_q.delete(); exp_addr.delete(); exp_data.delete();
        byte_q.push_back(nn[15:8]); x ^= nn[15:8];
        byte_q.push_back(nn[7:0]);  x ^= nn[7:0];
        if (n > DEPTH) begin
            exp_done = 1'b0; exp_err = 1'b1; exp_cnt = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = word_q[i];
            exp_addr.push_back((BASE + i) % DEPTH);
            exp_data.push_back(w);
            for (int b = 3; b >= 0; b--) begin
                byte_q.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
        byte_q.push_back(bad_csum ? (x ^ 8'h01) : x);
        exp_done = !bad_csum; exp_err = bad_csum; exp_cnt = n;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_bytes(input int count, input int gap_max, input bit mid_start);
        int w;
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b0;
            if (mid_start && i == 6) begin
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = byte_q[i];
            w = 0;
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            if (!in_ready) begin
                chk("byte_accept_timeout", 32'(i), 32'(count));
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_session(input int gap_max, input bit mid_start);
        wr_seen = 0;
        do_start();
        chk("start_err_clr", 32'(load_err), 32'd0);
        chk("start_done_clr", 32'(load_done), 32'd0);
        chk("start_hold", 32'(core_hold), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
        send_bytes(byte_q.size(), gap_max, mid_start);
        repeat (4) @(negedge clk);
        chk("end_done", 32'(load_done), 32'(exp_done));
        chk("end_err", 32'(load_err), 32'(exp_err));
        chk("end_hold", 32'(core_hold), 32'(!exp_done));
        chk("end_wcnt", 32'(word_cnt), 32'(exp_cnt));
        chk("end_ready", 32'(in_ready), 32'd0);
        chk("writes_left", 32'(exp_addr.size()), 32'd0);
        chk("writes_seen", 32'(wr_seen), 32'(exp_cnt));
    endtask

    // Per-cycle compare of the write port and status invariants.
    always @(negedge clk) begin
        if (rst_ldr) begin
            chk("done_err_excl", 32'(load_done && load_err), 32'd0);
            chk("hold_vs_done", 32'(core_hold), 32'(!load_done));
            if (im_we) begin
                wr_seen++;
                if (exp_addr.size() == 0) begin
                    chk("extra_write", 32'(wr_seen), 32'd0);
                end else begin
                    chk("wr_addr", 32'(im_waddr), 32'(exp_addr.pop_front()));
                    chk("wr_data", im_wdata, exp_data.pop_front());
                    chk("wr_wcnt", 32'(word_cnt), 32'(wr_seen));
                end
            end
        end
    end

    initial begin
        rst_ldr = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_waddr", 32'(im_waddr), 32'(BASE));
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        @(negedge clk); rst_ldr = 1'b1;

        // Test 1: known image, model pinned to literal bytes
        word_q = '{32'h20080005, 32'h01094020};
        model_build(2, 1'b0);
        chk("pin_len_lo", 32'(byte_q[1]), 32'h02);
        chk("pin_csum", 32'(byte_q[10]), 32'h47);
        chk("pin_w1", exp_data[1], 32'h01094020);
        run_session(0, 1'b0);
        chk("t1_wcnt", 32'(word_cnt), 32'd2);
        chk("t1_done", 32'(load_done), 32'd1);

        // Test 2: bad checksum (0x46)
        model_build(2, 1'b1);
        chk("pin_bad_csum", 32'(byte_q[10]), 32'h46);
        run_session(0, 1'b0);
        chk("t2_err", 32'(load_err), 32'd1);

        // Test 3: empty image
        word_q.delete();
        model_build(0, 1'b0);
        chk("pin_empty_len", 32'(byte_q.size()), 32'd3);
        run_session(0, 1'b0);

        // Test 4: oversize length 0x0401
        model_build(1025, 1'b0);
        run_session(0, 1'b0);
        chk("t4_err", 32'(load_err), 32'd1);

        // Test 5: gaps plus ignored start mid-DATA
        word_q = '{32'h20080005, 32'h01094020};
        model_build(2, 1'b0);
        run_session(5, 1'b1);

        // Test 6: asynchronous reset after 5th data byte, then a clean reload
        model_build(2, 1'b0);
        wr_seen = 0;
        do_start();
        send_bytes(7, 2, 1'b0);
        #2 rst_ldr = 1'b0;
        #1;
        chk("arst_hold", 32'(core_hold), 32'd1);
        chk("arst_we", 32'(im_we), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_wcnt", 32'(word_cnt), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_pending", 32'(exp_addr.size()), 32'd1);
        @(negedge clk); rst_ldr = 1'b1;
        model_build(2, 1'b0);
        run_session(1, 1'b0);

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            int n;
            n = $urandom_range(1, 12);
            word_q.delete();
            for (int i = 0; i < n; i++) word_q.push_back($urandom);
            model_build(n, ($urandom_range(0, 3) == 0));
            run_session($urandom_range(0, 3), ($urandom_range(0, 1) == 1) && n >= 2);
        end

        // Full-depth image (boundary N == depth)
        word_q.delete();
        for (int i = 0; i < DEPTH; i++) word_q.push_back($urandom);
        model_build(DEPTH, 1'b0);
        run_session(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
